cmp_seq: RTL and testbench

CMP_SEQ -- requirements
Module: cmp_seq

---
 rtl/cmp_seq_if.sv | 25 ++
 rtl/cmp_seq.sv | 105 ++++++++++
 tb/tb_cmp_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_seq_if.sv
// Handshake bundle for the digit-serial comparator: request side (start/a/b/sgn)
// and result side (busy/done/eq/lt/gt).
interface cmp_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, a, b, sgn,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/cmp_seq.sv
// Digit-serial magnitude comparator: examines DIGIT bits per cycle, MSB first,
// and exits early on the first differing slice.
//
// state | meaning
// IDLE  | waiting for start; operands not held
// CMP   | comparing top slice of the captured operands each cycle
// DONE  | results valid, done pulsed; may accept a new start on exit
module cmp_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic      clk,
  input logic      rst,
  cmp_seq_if.slave bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign cap_a   = bus.sgn ? (bus.a ^ MSB_MASK) : bus.a;
  assign cap_b   = bus.sgn ? (bus.b ^ MSB_MASK) : bus.b;

  // Operands are shifted left after each equal slice, so the live slice is always on top.
  assign slice_a = opa[WIDTH-1 -: DIGIT];
  assign slice_b = opb[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      opa      <= '0;
      opb      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.eq   <= 1'b0;
      bus.lt   <= 1'b0;
      bus.gt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa      <= cap_a;
            opb      <= cap_b;
            idx      <= IW'(ND - 1);
            bus.busy <= 1'b1;
            state    <= CMP;
          end
        end
        CMP: begin
          if (slice_a != slice_b) begin
            bus.gt   <= (slice_a > slice_b);
            bus.lt   <= (slice_a < slice_b);
            bus.eq   <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (idx == '0) begin
            bus.eq   <= 1'b1;
            bus.lt   <= 1'b0;
            bus.gt   <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx - IW'(1);
            opa <= opa << DIGIT;
            opb <= opb << DIGIT;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opa   <= cap_a;
            opb   <= cap_b;
            idx   <= IW'(ND - 1);
            state <= CMP;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_seq.sv
// Scoreboard bench for cmp_seq: stimulus pushes expected results and done edge,
// a negedge monitor pops and compares on every done pulse.
module tb_cmp_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic eq;
    logic lt;
    logic gt;
    int   done_edge;
    int   id;
  } exp_t;

  exp_t sb_q[$];
  int   next_id = 0;

  cmp_seq_if #(.WIDTH(8)) bus ();

  cmp_seq #(.WIDTH(8), .DIGIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_slices(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic [7:0] ua, ub;
    int k;
    ua = sv ? (av ^ 8'h80) : av;
    ub = sv ? (bv ^ 8'h80) : bv;
    k = 0;
    for (int i = 3; i >= 0; i--) begin
      k++;
      if (ua[i*2 +: 2] != ub[i*2 +: 2]) break;
    end
    return k;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      chk("done_pulse_width", int'(prev_done), 0);
      chk("busy_with_done", int'(bus.busy), 1);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 edge=%0d", edge_cnt);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("eq_id%0d", e.id), int'(bus.eq), int'(e.eq));
        chk($sformatf("lt_id%0d", e.id), int'(bus.lt), int'(e.lt));
        chk($sformatf("gt_id%0d", e.id), int'(bus.gt), int'(e.gt));
        chk($sformatf("latency_id%0d", e.id), edge_cnt, e.done_edge);
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic ee, input logic el, input logic eg, input int k);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.sgn   = sv;
    sb_q.push_back('{ee, el, eg, edge_cnt + 1 + k, next_id});
    next_id++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.sgn   = ~sv;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       eq;
    logic       lt;
    logic       gt;
    int         k;
  } vec_t;

  vec_t vecs[10] = '{
    '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4},
    '{8'hC0, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1},
    '{8'hC0, 8'h40, 1'b1, 1'b0, 1'b1, 1'b0, 1},
    '{8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 4},
    '{8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 4},
    '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1},
    '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1},
    '{8'h34, 8'h37, 1'b0, 1'b0, 1'b1, 1'b0, 4},
    '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1},
    '{8'h12, 8'h1A, 1'b0, 1'b0, 1'b1, 1'b0, 3}
  };

  initial begin
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.sgn   = 1'b0;

    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_eq",   int'(bus.eq),   0);
    chk("rst_lt",   int'(bus.lt),   0);
    chk("rst_gt",   int'(bus.gt),   0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].eq, vecs[i].lt, vecs[i].gt, vecs[i].k);

    // start held high: inputs changed while busy are ignored, re-accept on DONE exit
    begin
      int n;
      wait_idle();
      bus.start = 1'b1;
      bus.a     = 8'h10;
      bus.b     = 8'h20;
      bus.sgn   = 1'b0;
      n = edge_cnt + 1;
      sb_q.push_back('{1'b0, 1'b1, 1'b0, n + 2, next_id});
      next_id++;
      @(negedge clk);
      bus.a = 8'hFF;
      bus.b = 8'h00;
      @(negedge clk);
      @(negedge clk);
      bus.a = 8'h20;
      bus.b = 8'h10;
      sb_q.push_back('{1'b0, 1'b0, 1'b1, n + 5, next_id});
      next_id++;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'h00;
      bus.b     = 8'hFF;
    end

    // asynchronous reset mid-compare aborts with no done pulse
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h5A;
    bus.sgn   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_eq",   int'(bus.eq),   0);
    chk("arst_lt",   int'(bus.lt),   0);
    chk("arst_gt",   int'(bus.gt),   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1);

    // random sweep, both modes, biased toward shared upper slices
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] av, bv;
      logic       sv;
      int         ia, ib;
      av = 8'($urandom);
      case (i % 4)
        0: bv = av ^ 8'(1 << $urandom_range(7, 0));
        1: bv = av;
        default: bv = 8'($urandom);
      endcase
      sv = 1'(i % 2);
      ia = sv ? int'($signed(av)) : int'(av);
      ib = sv ? int'($signed(bv)) : int'(bv);
      issue(av, bv, sv, ia == ib, ia < ib, ia > ib, ref_slices(av, bv, sv));
    end

    begin
      int guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      chk("drain_outstanding", sb_q.size(), 0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
